// File: rtl/hms_bcd_counter.sv
// HH:MM:SS time-of-day counter held as six BCD digits, plus a free-running
// digit-scan select for the downstream 6:1 digit mux.
module hms_bcd_counter #(
    parameter int TICK_DIV = 1000,
    parameter int SCAN_DIV = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_set_min,
    input  logic       i_set_hour,
    output logic [3:0] o_sec_lo,
    output logic [3:0] o_sec_hi,
    output logic [3:0] o_min_lo,
    output logic [3:0] o_min_hi,
    output logic [3:0] o_hr_lo,
    output logic [3:0] o_hr_hi,
    output logic [2:0] o_sel,
    output logic       o_tick
);

    localparam int TW = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
    localparam int SW = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
    } bcd2_t;

    // Range checks use >= so a corrupted digit still returns to a legal value.
    function automatic bcd2_t inc_mod60(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.lo >= 4'd9) begin
            r.lo = 4'd0;
            r.hi = (v.hi >= 4'd5) ? 4'd0 : v.hi + 4'd1;
        end else begin
            r.lo = v.lo + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd2_t inc_mod24(input bcd2_t v);
        bcd2_t r;
        r = v;
        if ((v.hi >= 4'd2 && v.lo >= 4'd3) || v.hi > 4'd2) begin
            r = '0;
        end else if (v.lo >= 4'd9) begin
            r.lo = 4'd0;
            r.hi = v.hi + 4'd1;
        end else begin
            r.lo = v.lo + 4'd1;
        end
        return r;
    endfunction

    function automatic logic is_59(input bcd2_t v);
        return (v.hi == 4'd5) && (v.lo == 4'd9);
    endfunction

    bcd2_t          sec_q, sec_d;
    bcd2_t          min_q, min_d;
    bcd2_t          hr_q, hr_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]     sel_q, sel_d;
    logic           tick_q, tick_d;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        sec_d      = sec_q;
        min_d      = min_q;
        hr_d       = hr_q;
        tick_cnt_d = tick_cnt_q;
        scan_cnt_d = scan_cnt_q;
        sel_d      = sel_q;
        tick_d     = 1'b0;

        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            sel_d      = (sel_q >= 3'd5) ? 3'd0 : sel_q + 3'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end

        // Setting takes precedence over timekeeping; the two set inputs are independent.
        if (i_set_min || i_set_hour) begin
            if (i_set_min) begin
                min_d      = inc_mod60(min_q);
                sec_d      = '0;
                tick_cnt_d = '0;
            end
            if (i_set_hour) begin
                hr_d = inc_mod24(hr_q);
            end
        end else if (i_en) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = '0;
                tick_d     = 1'b1;
                sec_d      = inc_mod60(sec_q);
                if (is_59(sec_q)) begin
                    min_d = inc_mod60(min_q);
                    if (is_59(min_q)) begin
                        hr_d = inc_mod24(hr_q);
                    end
                end
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (i_rst) begin
            sec_q      <= '0;
            min_q      <= '0;
            hr_q       <= '0;
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            sel_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            sel_q      <= sel_d;
            tick_q     <= tick_d;
        end
    end

    assign o_sec_lo = sec_q.lo;
    assign o_sec_hi = sec_q.hi;
    assign o_min_lo = min_q.lo;
    assign o_min_hi = min_q.hi;
    assign o_hr_lo  = hr_q.lo;
    assign o_hr_hi  = hr_q.hi;
    assign o_sel    = sel_q;
    assign o_tick   = tick_q;

endmodule

// File: doc/hms_bcd_counter.md
Name: hms_bcd_counter

Overview:
- Time-of-day source for the six-digit display path: HH:MM:SS counter as six 4-bit BCD digits plus a free-running digit-scan select.
- Sits directly upstream of the 6:1 4-bit digit mux.
- Digit outputs map to mux inputs 0..5 as sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi.
- o_sel drives the mux select; the mux output feeds the 7-segment decoder.

Parameters:
TICK_DIV, 1000, i_clk cycles per one-second tick; must be >= 2.
SCAN_DIV, 10, i_clk cycles each digit select is held; must be >= 1.

Ports:
i_clk  input  1  Clock. Single clock domain; all state updates on the rising edge.
i_rst  input  1  Reset. Synchronous, active-high.
i_en  input  1  Run enable for timekeeping. High: the seconds prescaler advances.
i_set_min  input  1  While high, minutes increment once per cycle.
i_set_hour  input  1  While high, hours increment once per cycle.
o_sec_lo  output  4  Seconds units, BCD, 0..9.
o_sec_hi  output  4  Seconds tens, BCD, 0..5.
o_min_lo  output  4  Minutes units, BCD, 0..9.
o_min_hi  output  4  Minutes tens, BCD, 0..5.
o_hr_lo  output  4  Hours units, BCD, 0..9; 0..3 when o_hr_hi = 2.
o_hr_hi  output  4  Hours tens, BCD, 0..2.
o_sel  output  3  Digit-scan select, 0..5 only.
o_tick  output  1  One-cycle pulse each time seconds advance.

Behaviour:
- Reset (i_rst=1 at an edge): all digits 0, both prescalers 0, o_sel=0, o_tick=0. Reset overrides all other inputs. Reset mid-count discards the partial prescaler count.
- All outputs are registered; there are no combinational input-to-output paths.
- Priority per edge: reset > set inputs > tick.
- Seconds prescaler, counting 0..TICK_DIV-1:
  - Advances only when i_en=1 and both set inputs are 0.
  - On the edge where it equals TICK_DIV-1, it wraps to 0, o_tick is set to 1 and seconds increment on that same edge. Digits and o_tick therefore change in the same cycle.
  - o_tick is 0 on every other edge.
  - First tick: TICK_DIV edges after reset release with i_en held high.
- i_en=0: prescaler holds its value, digits freeze, o_tick=0. Resuming continues from the held count.
- Carry chain on a tick:
  - sec_lo 9->0 carries to sec_hi.
  - sec_hi=5 with sec_lo=9 -> 00 and carries to minutes.
  - Minutes use the same 00..59 rule and carry to hours.
  - Hours: hr_lo 9->0 with hr_hi+1. 23->00, no carry out.
  - 23:59:59 + tick -> 00:00:00 in one edge.
- i_set_min=1 at an edge:
  - Minutes +1 mod 60, with no carry into hours.
  - Seconds and the seconds prescaler clear to 0.
  - o_tick=0.
- i_set_hour=1 at an edge:
  - Hours +1 mod 24; 23 -> 00.
  - Seconds unchanged, prescaler holds, o_tick=0.
- Both set inputs high: both increments apply independently on the same edge, seconds and prescaler clear, and hours advance exactly once.
- Set inputs act regardless of i_en.
- Scan prescaler, counting 0..SCAN_DIV-1:
  - Always runs, independent of i_en and the set inputs.
  - At wrap, o_sel steps 0,1,2,3,4,5,0. Values 6 and 7 are never produced.
  - With SCAN_DIV=1, o_sel steps every cycle.
- Counter widths: $clog2 of the respective DIV, minimum 1 bit.
- Digit registers never hold non-BCD or out-of-range values under any input sequence.

Test Plan:
1. TICK_DIV=4, SCAN_DIV=2; reset, then i_en=1 for 12 cycles -> o_tick high on edges 4, 8, 12 only; o_sec_lo shows 1, 2, 3; other digits 0.
2. From reset, i_en=1 for 86400*4 cycles -> passes through 23:59:59, then reads 00:00:00 exactly at the final tick; o_hr_hi never exceeds 2.
3. Hold i_set_min for 60 cycles from 00:00:17 -> minutes pass 59 then 00; hours stay 00; seconds read 00 from the first edge; o_tick stays 0.
4. Hold i_set_hour for 25 cycles from 00:xx:xx -> hours step 01..23, 00, 01; a tick arriving during the set is suppressed.
5. i_en=0 for 20 cycles mid-second (prescaler=2) -> digits and o_tick frozen; o_sel keeps stepping; first tick arrives 2 edges after i_en returns to 1.
6. Assert i_rst for 1 cycle at 12:34:56 with o_sel=3 -> next cycle all digits 0, o_sel=0, o_tick=0; o_sel sequence 0,0,1,1,2,2,...,5,5,0 follows.
